// File: rtl/wm8750_cfg_seq.sv
// I2C write sequencer that walks a register table and programs a WM8750 codec.
// Each entry becomes one 3-byte write; NACKed entries are retried before failing.
`timescale 1ns/1ps
module wm8750_cfg_seq #(
  parameter int         CLK_DIV     = 125,
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 16,
  parameter int         MAX_RETRIES = 3,
  parameter int         GAP_TICKS   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  tbl_idx_o,
  input  logic [15:0] tbl_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_o,
  output logic [7:0]  fail_idx_o,
  output logic        scl_oe_o,
  output logic        sda_oe_o,
  input  logic        sda_i
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [7:0]    IDX_LAST  = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          load_cnt_q, load_cnt_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          ok_q, ok_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    fail_idx_q, fail_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    load_cnt_d = load_cnt_q;
    shreg_d    = shreg_q;
    gap_cnt_d  = gap_cnt_q;
    retry_d    = retry_q;
    ok_d       = ok_q;
    idx_d      = idx_q;
    fail_idx_d = fail_idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    nack_d     = nack_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;

    // Tick phase restarts at every frame so START lands a full tick after LOAD.
    if (state_q == S_IDLE || state_q == S_LOAD || state_q == S_DONE || state_q == S_FAIL) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d     = 1'b0;
          nack_d     = 1'b0;
          idx_d      = 8'd0;
          busy_d     = 1'b1;
          retry_d    = '0;
          load_cnt_d = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // Table read data trails the index by one cycle.
        if (!load_cnt_q) begin
          load_cnt_d = 1'b1;
        end else begin
          shreg_d    = {DEV_ADDR, 1'b0, tbl_data_i};
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 2'd0;
          phase_d    = 2'd0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (phase_q == 2'd0) begin
            sda_oe_d = 1'b1;
            phase_d  = 2'd1;
          end else begin
            scl_oe_d = 1'b1;
            phase_d  = 2'd0;
            state_d  = S_BIT;
          end
        end
      end
      S_BIT: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: sda_oe_d = ~shreg_q[23];
            2'd1: scl_oe_d = 1'b0;
            2'd2: ;
            default: begin
              scl_oe_d  = 1'b1;
              shreg_d   = {shreg_q[22:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = S_ACK;
            end
          endcase
        end
      end
      S_ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_oe_d = 1'b0;
            2'd2: ok_d     = ~sda_i;
            default: begin
              scl_oe_d = 1'b1;
              if (!ok_q || byte_cnt_q == 2'd2) begin
                phase_d = 2'd0;
                state_d = S_STOP;
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = S_BIT;
              end
            end
          endcase
        end
      end
      S_STOP: begin
        if (tick) begin
          case (phase_q)
            2'd0: begin
              sda_oe_d = 1'b1;
              phase_d  = 2'd1;
            end
            2'd1: begin
              scl_oe_d = 1'b0;
              phase_d  = 2'd2;
            end
            default: begin
              sda_oe_d  = 1'b0;
              phase_d   = 2'd0;
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          endcase
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end else if (ok_q) begin
            retry_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d      = idx_q + 8'd1;
              load_cnt_d = 1'b0;
              state_d    = S_LOAD;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d    = retry_q + 1'b1;
            load_cnt_d = 1'b0;
            state_d    = S_LOAD;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        nack_d     = 1'b1;
        fail_idx_d = idx_q;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      phase_q    <= 2'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      load_cnt_q <= 1'b0;
      shreg_q    <= 24'd0;
      gap_cnt_q  <= '0;
      retry_q    <= '0;
      ok_q       <= 1'b0;
      idx_q      <= 8'd0;
      fail_idx_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      load_cnt_q <= load_cnt_d;
      shreg_q    <= shreg_d;
      gap_cnt_q  <= gap_cnt_d;
      retry_q    <= retry_d;
      ok_q       <= ok_d;
      idx_q      <= idx_d;
      fail_idx_q <= fail_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign tbl_idx_o  = idx_q;
  assign fail_idx_o = fail_idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign nack_o     = nack_q;
  assign scl_oe_o   = scl_oe_q;
  assign sda_oe_o   = sda_oe_q;

endmodule

// File: tb/tb_wm8750_cfg_seq.sv
// Bench for wm8750_cfg_seq: I2C slave/bus monitor, frame-level reference model,
// directed and randomized table/NACK vectors, mid-frame start and reset sequences.
`timescale 1ns/1ps
module tb_wm8750_cfg_seq;
  localparam int CLK_DIV     = 2;
  localparam int NUM_REGS    = 2;
  localparam int MAX_RETRIES = 3;
  localparam int GAP_TICKS   = 8;
  localparam logic [7:0] ADDR_BYTE = 8'h34;  // 7'h1A shifted left, write bit 0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  tbl_idx_o;
  logic [15:0] tbl_data_i = 16'd0;
  logic        busy_o, done_o, nack_o;
  logic [7:0]  fail_idx_o;
  logic        scl_oe_o, sda_oe_o, sda_i;
  logic        slave_pull = 1'b0;

  logic [15:0]     tbl [0:1];
  logic [7:0][1:0] plan_cur;  // per frame: byte position the slave NACKs, 3 = none

  assign sda_i = ~(sda_oe_o | slave_pull);

  wm8750_cfg_seq #(
    .CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A), .NUM_REGS(NUM_REGS),
    .MAX_RETRIES(MAX_RETRIES), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .tbl_idx_o(tbl_idx_o),
    .tbl_data_i(tbl_data_i), .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o),
    .fail_idx_o(fail_idx_o), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o), .sda_i(sda_i)
  );

  always @(posedge clk) tbl_data_i <= tbl[tbl_idx_o[0]];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [1:0] plan_at(input int f);
    if (f >= 0 && f < 8) return plan_cur[f[2:0]];
    return 2'd3;
  endfunction

  // Bus monitor, slave and protocol checker
  logic [7:0] mon_bytes[$];
  int         mon_lens[$];
  logic       scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0;
  int         bitc = 0, bytepos = 0, nbytes = 0, cur_frame = 0, frame_no = 0;
  logic [7:0] cur = 8'd0;
  int         rise_t = 0, high_t = 0, hi_events = 0;
  logic       rise_v = 1'b0, high_v = 1'b0;

  always @(negedge clk) begin
    logic scl, sda;
    scl = ~scl_oe_o;
    sda = sda_i;
    if (rst_i) begin
      in_frame = 1'b0; bitc = 0; slave_pull = 1'b0; rise_v = 1'b0; high_v = 1'b0;
    end else if (scl_p && scl && (sda != sda_p)) begin
      hi_events++;
      if (!sda) begin
        chk("sda_fall_scl_high_is_start", int'(in_frame), 0);
        in_frame = 1'b1; bitc = 0; bytepos = 0; nbytes = 0; rise_v = 1'b0; high_v = 1'b0;
        cur_frame = frame_no; frame_no++;
      end else begin
        chk("sda_rise_scl_high_is_stop", int'(in_frame && bitc == 1 && cur[0] == 1'b0), 1);
        if (in_frame) mon_lens.push_back(nbytes);
        in_frame = 1'b0; bitc = 0; rise_v = 1'b0; high_v = 1'b0; slave_pull = 1'b0;
      end
    end else if (!scl_p && scl && in_frame) begin
      if (rise_v) chk("bit_cell_cycles", cycle - rise_t, 4 * CLK_DIV);
      rise_t = cycle; rise_v = 1'b1; high_t = cycle; high_v = 1'b1;
      if (bitc < 8) cur = {cur[6:0], sda};
      bitc++;
    end else if (scl_p && !scl && in_frame) begin
      if (high_v) chk("scl_high_cycles", cycle - high_t, 2 * CLK_DIV);
      high_v = 1'b0;
      if (bitc == 8) begin
        mon_bytes.push_back(cur);
        nbytes++;
        slave_pull = (int'(plan_at(cur_frame)) != bytepos);
      end else if (bitc == 9) begin
        slave_pull = 1'b0; bitc = 0; bytepos++;
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  // Reference model: expected frames from table contents, NACK plan and retry rules
  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  logic       e_done, e_nack;
  logic [7:0] e_fail;

  task automatic model_run();
    int idx, tries, pos, n;
    logic [7:0] b [3];
    exp_bytes.delete(); exp_lens.delete();
    idx = 0; tries = 0; e_done = 1'b0; e_nack = 1'b0; e_fail = 8'd0;
    for (int f = 0; f < 64; f++) begin
      b[0] = ADDR_BYTE; b[1] = tbl[idx][15:8]; b[2] = tbl[idx][7:0];
      pos = int'(plan_at(f));
      n = (pos == 3) ? 3 : pos + 1;
      for (int k = 0; k < n; k++) exp_bytes.push_back(b[k]);
      exp_lens.push_back(n);
      if (pos == 3) begin
        tries = 0;
        if (idx == NUM_REGS - 1) begin e_done = 1'b1; break; end
        idx++;
      end else if (tries < MAX_RETRIES) begin
        tries++;
      end else begin
        e_nack = 1'b1; e_fail = 8'(idx); break;
      end
    end
  endtask

  task automatic mon_clear();
    mon_bytes.delete(); mon_lens.delete(); frame_no = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_finish(output int busy_cycles);
    bit seen;
    busy_cycles = 0; seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (busy_o) busy_cycles++;
      if (!busy_o && (done_o || nack_o)) begin seen = 1'b1; break; end
    end
    chk("sequence_finished_in_budget", int'(seen), 1);
  endtask

  task automatic check_frames();
    chk("frame_count", mon_lens.size(), exp_lens.size());
    for (int i = 0; i < mon_lens.size() && i < exp_lens.size(); i++)
      chk("frame_len", mon_lens[i], exp_lens[i]);
    chk("byte_count", mon_bytes.size(), exp_bytes.size());
    for (int i = 0; i < mon_bytes.size() && i < exp_bytes.size(); i++)
      chk("bus_byte", int'(mon_bytes[i]), int'(exp_bytes[i]));
  endtask

  typedef struct {
    logic [15:0]     t0;
    logic [15:0]     t1;
    logic [7:0][1:0] plan;
    logic            done;
    logic            nack;
    logic [7:0]      fail_idx;
    int              frames;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic run_vec(input int v);
    int bc;
    tbl[0] = vecs[v].t0; tbl[1] = vecs[v].t1; plan_cur = vecs[v].plan;
    model_run();
    mon_clear();
    pulse_start();
    wait_finish(bc);
    repeat (2) @(negedge clk);
    check_frames();
    chk("frames_vs_table", mon_lens.size(), vecs[v].frames);
    chk("done_o", int'(done_o), int'(vecs[v].done));
    chk("nack_o", int'(nack_o), int'(vecs[v].nack));
    if (vecs[v].nack) chk("fail_idx_o", int'(fail_idx_o), int'(vecs[v].fail_idx));
    chk("busy_o_end", int'(busy_o), 0);
    chk("scl_released_end", int'(scl_oe_o), 0);
    chk("sda_released_end", int'(sda_oe_o), 0);
    if (v == 0) chk("busy_cycles_in_range", int'(bc >= 2 * 121 * 2 && bc <= 2 * 121 * 2 + 16), 1);
    $display("[TB] vec %0d tbl=%04h/%04h frames=%0d bytes=%0d busy=%0d done=%0b nack=%0b fail_idx=%0d",
             v, vecs[v].t0, vecs[v].t1, mon_lens.size(), mon_bytes.size(), bc, done_o, nack_o, fail_idx_o);
  endtask

  initial begin
    int bc, snap;
    bit found;
    tbl[0] = 16'd0; tbl[1] = 16'd0; plan_cur = {8{2'd3}};

    vecs[0] = '{16'h1E00, 16'h0E02, {8{2'd3}}, 1'b1, 1'b0, 8'd0, 2};
    vecs[1] = '{16'h1E00, 16'h0E02, {{7{2'd3}}, 2'd1}, 1'b1, 1'b0, 8'd0, 3};
    vecs[2] = '{16'h1E00, 16'h0E02, {8{2'd0}}, 1'b0, 1'b1, 8'd0, 4};
    for (int v = 3; v < NV; v++) begin
      vecs[v].t0 = 16'($urandom);
      vecs[v].t1 = 16'($urandom);
      for (int k = 0; k < 8; k++)
        vecs[v].plan[k] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      tbl[0] = vecs[v].t0; tbl[1] = vecs[v].t1; plan_cur = vecs[v].plan;
      model_run();
      vecs[v].done = e_done; vecs[v].nack = e_nack;
      vecs[v].fail_idx = e_fail; vecs[v].frames = exp_lens.size();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_nack", int'(nack_o), 0);
    chk("reset_idx", int'(tbl_idx_o), 0);
    chk("reset_fail_idx", int'(fail_idx_o), 0);
    chk("reset_scl_oe", int'(scl_oe_o), 0);
    chk("reset_sda_oe", int'(sda_oe_o), 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < NV; v++) run_vec(v);

    // start_i while busy must be ignored; a later start restarts from entry 0
    tbl[0] = vecs[0].t0; tbl[1] = vecs[0].t1; plan_cur = vecs[0].plan;
    model_run();
    mon_clear();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (tbl_idx_o == 8'd1 && in_frame && bytepos == 1) begin found = 1'b1; break; end
    end
    chk("midframe_point_reached", int'(found), 1);
    start_i = 1'b1;
    @(posedge clk); #1;
    chk("busy_start_ignored_idx", int'(tbl_idx_o), 1);
    chk("busy_start_ignored_busy", int'(busy_o), 1);
    start_i = 1'b0;
    wait_finish(bc);
    repeat (2) @(negedge clk);
    check_frames();
    chk("midframe_done", int'(done_o), 1);
    $display("[TB] midframe start: frames=%0d done=%0b", mon_lens.size(), done_o);
    mon_clear();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1;
    chk("restart_clears_done", int'(done_o), 0);
    chk("restart_busy", int'(busy_o), 1);
    chk("restart_idx", int'(tbl_idx_o), 0);
    start_i = 1'b0;
    wait_finish(bc);
    repeat (2) @(negedge clk);
    check_frames();
    chk("restart_done", int'(done_o), 1);
    $display("[TB] restart: frames=%0d bytes=%0d done=%0b", mon_lens.size(), mon_bytes.size(), done_o);

    // Reset during the bit cells of byte 1
    mon_clear();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (in_frame && bytepos == 1 && bitc >= 3 && scl_oe_o) begin found = 1'b1; break; end
    end
    chk("reset_point_reached", int'(found), 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("midreset_scl_oe", int'(scl_oe_o), 0);
    chk("midreset_sda_oe", int'(sda_oe_o), 0);
    chk("midreset_busy", int'(busy_o), 0);
    chk("midreset_idx", int'(tbl_idx_o), 0);
    chk("midreset_done", int'(done_o), 0);
    rst_i = 1'b0;
    snap = hi_events;
    repeat (100) @(posedge clk);
    chk("sda_edges_scl_high_after_reset", hi_events - snap, 0);
    $display("[TB] midframe reset: busy=%0b scl_oe=%0b sda_oe=%0b", busy_o, scl_oe_o, sda_oe_o);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm8750_cfg_seq.md
Name: wm8750_cfg_seq

Overview:
- Hardware I2C write sequencer that configures the WM8750 codec from a register table, so firmware no longer has to bit-bang SDA/SCL through GPIO 5/6.
- On start, it walks table entries 0..NUM_REGS-1 and issues one 3-byte I2C write per entry: device address, then the 16-bit WM8750 control word ({reg[6:0], data[8:0]}).
- It sits beside the audio output block and drives codec_scl/codec_sda through top-level open-drain muxing.
- It retries NACKed entries and reports done/nack status.

Parameters:
- CLK_DIV, 125: clk_i cycles per quarter-bit tick. 50 MHz / (4*125) = 100 kHz SCL.
- DEV_ADDR, 7'h1A: WM8750 7-bit I2C address (CSB low).
- NUM_REGS, 16: table entries to write (1..255).
- MAX_RETRIES, 3: extra attempts per entry after a NACK.
- GAP_TICKS, 8: idle ticks, bus released, between frames.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: reset. Synchronous, active-high.
- start_i, input, 1: one-cycle pulse; begins the sequence from entry 0.
- tbl_idx_o, output, 8: current table index.
- tbl_data_i, input, 16: control word for tbl_idx_o, valid 1 cycle after tbl_idx_o changes.
- busy_o, output, 1: sequence in progress.
- done_o, output, 1: all entries ACKed. Sticky.
- nack_o, output, 1: entry failed after all retries. Sticky.
- fail_idx_o, output, 8: index of the failed entry.
- scl_oe_o, output, 1: 1 = pull SCL low, 0 = release.
- sda_oe_o, output, 1: 1 = pull SDA low, 0 = release.
- sda_i, input, 1: SDA pin level (synchronised externally).

Behaviour:
- Reset: busy_o, done_o, nack_o = 0; tbl_idx_o, fail_idx_o = 0; scl_oe_o = sda_oe_o = 0 (bus released); tick counter, retry counter, state = IDLE. Reset mid-frame releases the bus on the next cycle; no STOP is generated.
- Tick: a counter that pulses every CLK_DIV cycles while busy; it is cleared in IDLE. All bus-pin changes occur only on ticks.
- States: IDLE, LOAD, START, BIT, ACK, STOP, GAP, DONE, FAIL.
- IDLE: a start_i pulse clears done_o/nack_o, sets tbl_idx_o = 0, sets busy_o = 1 next cycle, then goes to LOAD. start_i is ignored while busy_o = 1.
- LOAD: wait 2 cycles, then latch tbl_data_i into a 24-bit shift register {DEV_ADDR, 1'b0, tbl_data_i}, clear the bit counter, go to START.
- START (2 ticks, SCL released):
  - tick1: sda_oe = 1.
  - tick2: scl_oe = 1.
- BIT (4 ticks per bit, MSB first):
  - ph0: set sda_oe = ~bit.
  - ph1: release SCL.
  - ph2: hold.
  - ph3: pull SCL.
  - After 8 bits go to ACK.
- ACK (4 ticks): sda_oe = 0 at ph0; sample sda_i at ph2. 0 = ACK, 1 = NACK.
  - ACK after byte 0 or 1: continue to the next byte.
  - ACK after byte 2: go to STOP (success).
  - NACK: go to STOP (abort) immediately.
- STOP (3 ticks):
  - tick1: sda_oe = 1.
  - tick2: scl_oe = 0.
  - tick3: sda_oe = 0.
- One full frame = 2 + 27*4 + 3 = 113 ticks.
- GAP: GAP_TICKS ticks with the bus released, then:
  - After success: clear retry count. If tbl_idx_o == NUM_REGS-1, go to DONE; else tbl_idx_o++ and go to LOAD.
  - After abort: if retry count < MAX_RETRIES, retry++ and go to LOAD with the same index; else go to FAIL.
- DONE: done_o = 1, busy_o = 0, return to IDLE.
- FAIL: nack_o = 1, fail_idx_o = tbl_idx_o, busy_o = 0, return to IDLE.
- A start_i pulse coinciding with the DONE/FAIL cycle is ignored; it is accepted from IDLE onward.
- SDA is never changed while SCL is released, except in the START/STOP conditions.

Test Plan:
1. CLK_DIV=2, NUM_REGS=2, table {0x1E00, 0x0E02}, slave model ACKs all bytes; pulse start_i.
   - Required: bytes on the bus are 0x34,0x1E,0x00 then 0x34,0x0E,0x02.
   - busy_o is high for 2*(113+8)*2 cycles plus LOAD overhead; then done_o = 1, nack_o = 0.
2. Slave NACKs the 2nd byte of entry 0 once, then ACKs.
   - Required: frame aborts after ACK bit 2 with a STOP; entry 0 is resent after GAP.
   - done_o = 1; exactly 3 frames on the bus.
3. Slave NACKs the address byte forever, MAX_RETRIES=3.
   - Required: exactly 4 frames, each containing 1 byte then STOP; nack_o = 1, fail_idx_o = 0, done_o = 0, bus released.
4. Pulse start_i mid-frame, then again after done_o.
   - Required: the first pulse has no effect.
   - The second pulse clears done_o, restarts from tbl_idx_o = 0, and reproduces scenario 1's bytes.
5. Assert rst_i during the BIT state of byte 1.
   - Required: on the next cycle scl_oe_o = sda_oe_o = 0, busy_o = 0, tbl_idx_o = 0; the bus monitor reports no SDA edge while SCL is high after reset.
6. Protocol checker throughout all tests.
   - Required: SDA is stable whenever SCL is high, except START/STOP.
   - The SCL high period is 2 ticks and each bit cell is 4 ticks (8 cycles at CLK_DIV=2).
